// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM read port and loads the IF/ID register.
// Optional misaligned-fetch detection is compiled in with INST_FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic [31:0] rom_data,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic [31:0] fetch_cnt
`ifdef INST_FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_adel
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] next_pc_s;
    logic        rom_ce_r;
    logic        rom_ce_nxt_s;
    logic        pend_valid_r;
    logic [31:0] pend_target_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_inst_r;
    logic        id_valid_r;
    logic [31:0] fetch_cnt_r;
    logic        commit_s;
    logic        pend_load_s;
    logic        misaligned_s;

    // Redirect selection and the decision whether this edge commits an instruction.
    always_comb begin
        commit_s    = 1'b0;
        pend_load_s = 1'b0;
        next_pc_s   = pc_r + PC_STEP;
        if (branch_flag) begin
            next_pc_s = branch_target;
        end else if (pend_valid_r) begin
            next_pc_s = pend_target_r;
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end
        if ((state_r == ST_FETCH) && !stall && !flush) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
        // A redirect that cannot be taken on this edge is parked until the next commit.
        if (branch_flag && !flush && !commit_s) begin
            pend_load_s = 1'b1;
        end else begin
            pend_load_s = 1'b0;
        end
    end

    // Misaligned-PC detection, only meaningful when the check is compiled in.
    always_comb begin
        misaligned_s = 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if (pc_r[1:0] != 2'b00) begin
            misaligned_s = 1'b1;
        end else begin
            misaligned_s = 1'b0;
        end
`endif
    end

    // Next-state, next-PC and next read-enable.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        rom_ce_nxt_s = 1'b0;
        if (flush) begin
            state_nxt_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = ST_FETCH;
                ST_FETCH: state_nxt_s = stall ? ST_HOLD : ST_FETCH;
                ST_HOLD:  state_nxt_s = stall ? ST_HOLD : ST_FETCH;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
        if (flush) begin
            pc_nxt_s = flush_pc;
        end else if (commit_s) begin
            pc_nxt_s = next_pc_s;
        end else begin
            pc_nxt_s = pc_r;
        end
`ifdef INST_FETCH_ALIGN_CHECK_EN
        rom_ce_nxt_s = (state_nxt_s != ST_IDLE) && (pc_nxt_s[1:0] == 2'b00);
`else
        rom_ce_nxt_s = (state_nxt_s != ST_IDLE);
`endif
    end

    // State, PC and ROM enable registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            rom_ce_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            rom_ce_r <= rom_ce_nxt_s;
        end
    end

    // Pending redirect captured while the fetch cannot advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
        end else if (flush) begin
            pend_valid_r  <= 1'b0;
            pend_target_r <= pend_target_r;
        end else if (pend_load_s) begin
            pend_valid_r  <= 1'b1;
            pend_target_r <= branch_target;
        end else if (commit_s) begin
            pend_valid_r  <= 1'b0;
            pend_target_r <= pend_target_r;
        end else begin
            pend_valid_r  <= pend_valid_r;
            pend_target_r <= pend_target_r;
        end
    end

    // IF/ID pipeline register; the delay-slot word is never squashed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc_r    <= 32'h0000_0000;
            id_inst_r  <= 32'h0000_0000;
            id_valid_r <= 1'b0;
        end else if (flush) begin
            id_pc_r    <= id_pc_r;
            id_inst_r  <= 32'h0000_0000;
            id_valid_r <= 1'b0;
        end else if (commit_s && misaligned_s) begin
            id_pc_r    <= pc_r;
            id_inst_r  <= 32'h0000_0000;
            id_valid_r <= 1'b0;
        end else if (commit_s) begin
            id_pc_r    <= pc_r;
            id_inst_r  <= rom_data;
            id_valid_r <= 1'b1;
        end else begin
            id_pc_r    <= id_pc_r;
            id_inst_r  <= id_inst_r;
            id_valid_r <= id_valid_r;
        end
    end

    // Committed-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_r <= 32'h0000_0000;
        end else if (commit_s && !misaligned_s) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
        end else begin
            fetch_cnt_r <= fetch_cnt_r;
        end
    end

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic fetch_adel_r;

    // Address-error pulse for the cycle after a misaligned fetch attempt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_adel_r <= 1'b0;
        end else begin
            fetch_adel_r <= commit_s && misaligned_s;
        end
    end

    assign fetch_adel = fetch_adel_r;
`endif

    assign rom_ce    = rom_ce_r;
    assign rom_addr  = pc_r;
    assign id_pc     = id_pc_r;
    assign id_inst   = id_inst_r;
    assign id_valid  = id_valid_r;
    assign fetch_cnt = fetch_cnt_r;

endmodule
